// File: rtl/adc_emul_pkg.sv
// Shared types and default sizes for the ADC emulator burst sequencer.
package adc_emul_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int LEN_W_DEF = 16;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
    typedef enum logic {UP = 1'b0, DOWN = 1'b1} dir_t;

endpackage

// File: rtl/adc_emul_tri_step.sv
// Combinational triangle-wave step: next value and direction, clamped exactly at lo/hi.
module tri_step
    import adc_emul_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] value,
    input  logic             dir,
    input  logic [WIDTH-1:0] step,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] value_nx,
    output logic             dir_nx
);

    // Distances are taken before adding/subtracting, so lo <= value <= hi never wraps.
    always_comb begin
        value_nx = value;
        dir_nx   = dir;
        if (dir == UP) begin
            if (hi - value <= step) begin
                value_nx = hi;
                dir_nx   = DOWN;
            end else begin
                value_nx = value + step;
            end
        end else begin
            if (value - lo <= step) begin
                value_nx = lo;
                dir_nx   = UP;
            end else begin
                value_nx = value - step;
            end
        end
    end

endmodule

// File: rtl/adc_emul_ctrl.sv
// Burst sequencer emitting bounded triangle-wave samples on a valid/ready stream.
// Define ADC_EMUL_CTRL_HDR_EN to prefix each burst with a burst-number header beat.
module adc_emul_ctrl
    import adc_emul_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] cfg_step,
    input  logic [WIDTH-1:0] cfg_lo,
    input  logic [WIDTH-1:0] cfg_hi,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             start,
    input  logic             stop,
    output logic             busy,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last,
    output logic             done,
    output logic             aborted,
    output logic             err_cfg
);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] value_reg, value_next;
    dir_t             dir_reg, dir_next;
    logic [LEN_W-1:0] count_reg, count_next;
    logic [WIDTH-1:0] step_reg, step_next, lo_reg, lo_next, hi_reg, hi_next;
    logic [LEN_W-1:0] len_reg, len_next;
    logic             stop_pend_reg, stop_pend_next;
    logic [WIDTH-1:0] m_data_reg, m_data_next;
    logic             m_valid_reg, m_valid_next, m_last_reg, m_last_next;
    logic             busy_reg, busy_next, done_reg, done_next;
    logic             aborted_reg, aborted_next, err_cfg_reg, err_cfg_next;
    logic [WIDTH-1:0] step_value;
    logic             step_dir;
    logic             cfg_ok, accept, stop_req, hdr_beat, fin, fin_abort;

`ifdef ADC_EMUL_CTRL_HDR_EN
    logic             hdr_reg, hdr_next;
    logic [LEN_W-1:0] burst_reg, burst_next;
    assign hdr_beat = hdr_reg;
`else
    assign hdr_beat = 1'b0;
`endif

    tri_step #(.WIDTH(WIDTH)) u_tri_step (
        .value    (value_reg),
        .dir      (dir_reg),
        .step     (step_reg),
        .lo       (lo_reg),
        .hi       (hi_reg),
        .value_nx (step_value),
        .dir_nx   (step_dir)
    );

    assign cfg_ok   = (cfg_lo < cfg_hi) && (cfg_step != '0) &&
                      (cfg_step <= cfg_hi - cfg_lo) && (cfg_len != '0);
    assign accept   = m_valid_reg & m_ready;
    assign stop_req = stop | stop_pend_reg;

    always_comb begin
        state_next     = state_reg;
        value_next     = value_reg;
        dir_next       = dir_reg;
        count_next     = count_reg;
        step_next      = step_reg;
        lo_next        = lo_reg;
        hi_next        = hi_reg;
        len_next       = len_reg;
        stop_pend_next = stop_pend_reg;
        m_data_next    = m_data_reg;
        m_valid_next   = m_valid_reg;
        m_last_next    = m_last_reg;
        busy_next      = busy_reg;
        done_next      = 1'b0;
        aborted_next   = 1'b0;
        err_cfg_next   = 1'b0;
        fin            = 1'b0;
        fin_abort      = 1'b0;
`ifdef ADC_EMUL_CTRL_HDR_EN
        hdr_next       = hdr_reg;
        burst_next     = burst_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (cfg_ok) begin
                        step_next      = cfg_step;
                        lo_next        = cfg_lo;
                        hi_next        = cfg_hi;
                        len_next       = cfg_len;
                        value_next     = cfg_lo;
                        dir_next       = UP;
                        count_next     = '0;
                        stop_pend_next = 1'b0;
                        m_valid_next   = 1'b1;
                        busy_next      = 1'b1;
                        state_next     = RUN;
`ifdef ADC_EMUL_CTRL_HDR_EN
                        hdr_next       = 1'b1;
                        burst_next     = burst_reg + LEN_W'(1);
                        m_data_next    = WIDTH'(burst_reg);
                        m_last_next    = 1'b0;
`else
                        m_data_next    = cfg_lo;
                        m_last_next    = (cfg_len == LEN_W'(1));
`endif
                    end else begin
                        err_cfg_next = 1'b1;
                    end
                end
            end
            RUN: begin
                if (stop) stop_pend_next = 1'b1;
                if (accept) begin
                    if (hdr_beat) begin
                        // Header accepted: first sample (lo) was preloaded at start.
                        if (stop_req) begin
                            fin       = 1'b1;
                            fin_abort = 1'b1;
                        end else begin
                            m_data_next = value_reg;
                            m_last_next = (len_reg == LEN_W'(1));
                        end
                    end else if (m_last_reg) begin
                        fin = 1'b1;
                    end else if (stop_req) begin
                        fin       = 1'b1;
                        fin_abort = 1'b1;
                    end else begin
                        value_next  = step_value;
                        dir_next    = dir_t'(step_dir);
                        count_next  = count_reg + LEN_W'(1);
                        m_data_next = step_value;
                        m_last_next = ((count_reg + LEN_W'(2)) == len_reg);
                    end
`ifdef ADC_EMUL_CTRL_HDR_EN
                    hdr_next = 1'b0;
`endif
                end
            end
            default: state_next = IDLE;
        endcase

        if (fin) begin
            state_next     = IDLE;
            m_valid_next   = 1'b0;
            m_last_next    = 1'b0;
            busy_next      = 1'b0;
            done_next      = 1'b1;
            aborted_next   = fin_abort;
            stop_pend_next = 1'b0;
            count_next     = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            value_reg     <= '0;
            dir_reg       <= UP;
            count_reg     <= '0;
            step_reg      <= '0;
            lo_reg        <= '0;
            hi_reg        <= '0;
            len_reg       <= '0;
            stop_pend_reg <= 1'b0;
            m_data_reg    <= '0;
            m_valid_reg   <= 1'b0;
            m_last_reg    <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            aborted_reg   <= 1'b0;
            err_cfg_reg   <= 1'b0;
`ifdef ADC_EMUL_CTRL_HDR_EN
            hdr_reg       <= 1'b0;
            burst_reg     <= '0;
`endif
        end else begin
            state_reg     <= state_next;
            value_reg     <= value_next;
            dir_reg       <= dir_next;
            count_reg     <= count_next;
            step_reg      <= step_next;
            lo_reg        <= lo_next;
            hi_reg        <= hi_next;
            len_reg       <= len_next;
            stop_pend_reg <= stop_pend_next;
            m_data_reg    <= m_data_next;
            m_valid_reg   <= m_valid_next;
            m_last_reg    <= m_last_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            aborted_reg   <= aborted_next;
            err_cfg_reg   <= err_cfg_next;
`ifdef ADC_EMUL_CTRL_HDR_EN
            hdr_reg       <= hdr_next;
            burst_reg     <= burst_next;
`endif
        end
    end

    assign busy    = busy_reg;
    assign m_data  = m_data_reg;
    assign m_valid = m_valid_reg;
    assign m_last  = m_last_reg;
    assign done    = done_reg;
    assign aborted = aborted_reg;
    assign err_cfg = err_cfg_reg;

endmodule

// File: tb/tb_adc_emul_ctrl.sv
// Self-checking bench for adc_emul_ctrl: randomized bursts against a closed-form triangle model.
module tb_adc_emul_ctrl;

    localparam int WIDTH = 32;
    localparam int LEN_W = 16;
`ifdef ADC_EMUL_CTRL_HDR_EN
    localparam bit HDR = 1'b1;
`else
    localparam bit HDR = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [WIDTH-1:0] cfg_step = '0, cfg_lo = '0, cfg_hi = '0;
    logic [LEN_W-1:0] cfg_len = '0;
    logic             start = 1'b0, stop = 1'b0, m_ready = 1'b0;
    logic             busy, m_valid, m_last, done, aborted, err_cfg;
    logic [WIDTH-1:0] m_data;

    int     n_checks = 0;
    int     n_pass = 0;
    int     burst_num = 0;
    longint exp_q[$];

    adc_emul_ctrl #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .cfg_step (cfg_step),
        .cfg_lo   (cfg_lo),
        .cfg_hi   (cfg_hi),
        .cfg_len  (cfg_len),
        .start    (start),
        .stop     (stop),
        .busy     (busy),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_last   (m_last),
        .done     (done),
        .aborted  (aborted),
        .err_cfg  (err_cfg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Sample i of a triangle that rises from lo in steps, clamps at hi, falls and clamps at lo.
    function automatic longint tri_sample(input longint lo, input longint hi,
                                          input longint step, input int i);
        longint k, p, v;
        k = (hi - lo + step - 1) / step;
        p = longint'(i) % (2 * k);
        if (p <= k) begin
            v = lo + p * step;
            if (v > hi) v = hi;
        end else begin
            v = hi - (p - k) * step;
            if (v < lo) v = lo;
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_burst(input longint lo, input longint hi, input longint step,
                             input int len, input int stop_after, input int rmode);
        int total, expect_n, accepted;
        bit stop_sent, acc, exp_abort, held_valid;
        longint held;
        exp_q.delete();
        if (HDR) exp_q.push_back(longint'(burst_num % 65536));
        for (int i = 0; i < len; i++) exp_q.push_back(tri_sample(lo, hi, step, i));
        total     = exp_q.size();
        expect_n  = (stop_after >= 0 && stop_after + 1 < total) ? stop_after + 1 : total;
        exp_abort = (expect_n < total);
        cfg_lo   = WIDTH'(lo);
        cfg_hi   = WIDTH'(hi);
        cfg_step = WIDTH'(step);
        cfg_len  = LEN_W'(len);
        start    = 1'b1;
        tick();
        start = 1'b0;
        burst_num++;
        check("busy_on", busy, 1);
        check("done_clr", done, 0);
        accepted   = 0;
        stop_sent  = 1'b0;
        held_valid = 1'b0;
        held       = 0;
        for (int cyc = 0; cyc < 4000 && accepted < expect_n; cyc++) begin
            if (!m_valid) begin
                check("valid_drop", 0, 1);
                break;
            end
            if (held_valid) check("hold_data", m_data, held);
            check("data", m_data, exp_q[accepted]);
            check("last", m_last, longint'(accepted == total - 1));
            if (stop_after >= 0 && accepted == stop_after && !stop_sent) begin
                stop = 1'b1;
                stop_sent = 1'b1;
            end else begin
                stop = 1'b0;
            end
            case (rmode)
                0:       m_ready = 1'b1;
                1:       m_ready = (cyc % 2 == 0);
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            acc        = m_ready;
            held       = m_data;
            held_valid = !acc;
            tick();
            if (acc) accepted++;
        end
        stop = 1'b0;
        check("accept_count", accepted, expect_n);
        check("done", done, 1);
        check("aborted", aborted, exp_abort);
        check("valid_off", m_valid, 0);
        check("busy_off", busy, 0);
        $display("burst lo=%0d hi=%0d step=%0d len=%0d stop_after=%0d ready_mode=%0d beats=%0d aborted=%0d",
                 lo, hi, step, len, stop_after, rmode, accepted, exp_abort);
    endtask

    task automatic err_case(input longint lo, input longint hi, input longint step, input int len);
        cfg_lo   = WIDTH'(lo);
        cfg_hi   = WIDTH'(hi);
        cfg_step = WIDTH'(step);
        cfg_len  = LEN_W'(len);
        start    = 1'b1;
        tick();
        start = 1'b0;
        check("err_pulse", err_cfg, 1);
        check("err_valid", m_valid, 0);
        check("err_busy", busy, 0);
        tick();
        check("err_clr", err_cfg, 0);
        check("err_valid2", m_valid, 0);
        $display("reject lo=%0d hi=%0d step=%0d len=%0d", lo, hi, step, len);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        longint lo, range;
        int     len, sa;

        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", {m_data, m_valid, m_last, busy, done, aborted, err_cfg}, 0);
        reset = 1'b1;
        tick();

        run_burst(0, 4, 1, 10, -1, 0);
        run_burst(0, 7, 3, 8, -1, 0);
        run_burst(0, 4, 1, 10, -1, 1);
        run_burst(10, 1000, 7, 100, 5, 0);
        tick();
        check("done_pulse_end", done, 0);
        check("aborted_pulse_end", aborted, 0);

        err_case(5, 5, 1, 4);
        err_case(0, 10, 0, 4);
        err_case(0, 10, 2, 0);
        err_case(0, 10, 11, 4);

        run_burst(64'hFFFF_FF00, 64'hFFFF_FFFF, 100, 12, -1, 2);
        run_burst(3, 9, 6, 5, 4, 2);
        for (int n = 0; n < 10; n++) begin
            lo    = longint'($urandom_range(0, 32'hFFFF_0000));
            range = longint'($urandom_range(1, 60));
            len   = int'($urandom_range(1, 40));
            sa    = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, len + 1)) : -1;
            run_burst(lo, lo + range, longint'($urandom_range(1, 32'(range))), len, sa, 2);
        end

        // Reset in the middle of a running burst.
        cfg_lo = 0; cfg_hi = 4; cfg_step = 1; cfg_len = 10;
        start = 1'b1;
        tick();
        start = 1'b0;
        m_ready = 1'b1;
        repeat (3) tick();
        #2;
        reset = 1'b0;
        #1;
        check("midreset_outs", {m_data, m_valid, m_last, busy, done, aborted, err_cfg}, 0);
        tick();
        check("midreset_hold", {m_data, m_valid, m_last, busy, done, aborted, err_cfg}, 0);
        reset = 1'b1;
        burst_num = 0;
        $display("reset asserted mid-burst and released");
        tick();
        run_burst(0, 4, 1, 10, -1, 0);
        run_burst(0, 4, 1, 10, -1, 2);
        tick();
        check("done_final_clr", done, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/adc_emul_ctrl.md
# adc_emul_ctrl

Burst sequencer for the ADC emulator datapath. It takes a software-style configuration (step, low/high bounds, burst length) and a start/stop command. It generates bounded triangle-wave samples and delivers them as a valid/ready stream with a last-beat marker. It sits between the control register bank and the sample sink, and replaces the free-running emulator counter with a controllable, back-pressurable source.

## Interface
- WIDTH, 32, sample width in bits
- LEN_W, 16, burst-length counter width
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- cfg_step  in  WIDTH  increment per beat
- cfg_lo  in  WIDTH  lower turn-around bound (unsigned)
- cfg_hi  in  WIDTH  upper turn-around bound (unsigned)
- cfg_len  in  LEN_W  sample beats per burst
- start  in  1  start pulse; sampled only in IDLE
- stop  in  1  abort request; sampled only in RUN
- busy  out  1  high in RUN
- m_data  out  WIDTH  sample value
- m_valid  out  1  beat valid
- m_ready  in  1  sink ready
- m_last  out  1  final beat of a complete burst
- done  out  1  one-cycle pulse at end of burst
- aborted  out  1  qualifies done: burst ended by stop
- err_cfg  out  1  one-cycle pulse: start rejected

## Operation
- States: IDLE, RUN.
- IDLE + start:
  - Config is valid when cfg_lo < cfg_hi, cfg_step != 0, cfg_step <= cfg_hi - cfg_lo and cfg_len != 0.
  - If valid: latch all cfg_* inputs, set value = cfg_lo, dir = up, count = 0, enter RUN.
  - If invalid: pulse err_cfg and stay in IDLE.
- cfg_* changes during RUN have no effect, because the config was latched at start.
- RUN: m_valid = 1 and m_data = value. On accept (m_valid & m_ready), count increments and value advances:
  - up: if hi - value <= step, then value = hi and dir = down; otherwise value += step.
  - down: if value - lo <= step, then value = lo and dir = up; otherwise value -= step.
  - Bounds are reached exactly and never overshot. Arithmetic is unsigned WIDTH-bit and cannot wrap, because every comparison is made before the add or subtract.
- m_last = 1 when count == len-1. Accepting that beat ends the burst: done pulses, aborted = 0, state returns to IDLE.
- stop in RUN sets stop_pend. The next accepted beat ends the burst: done pulses with aborted = 1. m_last is not asserted for an aborted burst.
  - If that beat is also the len-1 beat, it is a normal completion: m_last = 1 and aborted = 0.
- Stream rule: while m_valid & !m_ready, m_data and m_last hold stable. stop never withdraws m_valid.
- start in RUN is ignored. stop in IDLE is ignored.
- Reset (any state): state = IDLE, and all outputs are 0 (m_data, m_valid, m_last, busy, done, aborted, err_cfg). stop_pend and the burst counter are cleared. A beat in flight is dropped.

## Timing
- start sampled at edge N → m_valid = 1 and busy = 1 after edge N.
- err_cfg is high for the cycle after edge N.
- Throughput is 1 beat/clk with m_ready held high. The next m_data appears the cycle after an accept.
- Last beat accepted at edge M → done (and aborted) high for the cycle after M. m_valid and busy are low after M.
- A new start is accepted during the done cycle, which gives back-to-back bursts with a 1-cycle gap.
- All outputs are registered. There is no combinational path from m_ready to any output.

## Configuration
- ADC_EMUL_CTRL_HDR_EN defined:
  - Each burst begins with one header beat, m_data = burst number (LEN_W-bit wrap counter, zero-extended, cleared by reset, incremented per started burst).
  - The header is not counted in cfg_len and never has m_last set.
  - stop during the header ends the burst after the header is accepted.
- ADC_EMUL_CTRL_HDR_EN undefined: no header; the first beat is cfg_lo.

## Structure
- Package adc_emul_pkg holds:
  - the state enum (IDLE, RUN)
  - direction enum (UP, DOWN)
  - default WIDTH / LEN_W constants
- Sub-module tri_step: combinational next-value/next-dir computation (value, dir, step, lo, hi → value_nx, dir_nx), reused by future emulator variants.
- The FSM, counter and stream registers live in adc_emul_ctrl.

## Test plan
- lo=0, hi=4, step=1, len=10, ready=1 → m_data 0,1,2,3,4,3,2,1,0,1; m_last on the 10th beat; done one cycle later with aborted=0.
- lo=0, hi=7, step=3, len=8 → 0,3,6,7,4,1,0,3 (clamped turn-arounds at bounds).
- Same as the first case with m_ready toggled 1010… → identical data sequence; m_data stable whenever valid & !ready; 10 accepts.
- len=100, stop after 5 accepts → exactly 6 beats accepted; m_last never set; done & aborted pulse.
- start with lo=5, hi=5 (or step=0, or len=0) → err_cfg pulse, m_valid stays 0, busy stays 0.
- Reset asserted mid-burst, then released and restarted with the first config → all outputs 0 during reset; the new burst starts at lo with a full count. With HDR_EN: the first beat is header 0, then header 1 on the next burst.
